ysyx_22041752_ifetch_bridge: RTL and testbench

Instruction-side responder that services the fetch unit's SRAM-style request port (inst_en / inst_addr / inst_ready / inst_rdata) and turns each accepted fetch into one AXI4-Lite read transaction on the memory bus. It sits between the fetch stage and the instruction-side bus interconnect. It holds the returned doubleword stable until the next response. It also handles redirect flushes by discarding stale responses.

---
 rtl/ysyx_22041752_ifetch_bridge.sv | 142 ++++++++++++++
 tb/tb_ysyx_22041752_ifetch_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_ifetch_bridge.sv
// Fetch-side bridge: SRAM-style fetch port to a single AXI4-Lite read.
// Optional one-entry line buffer: define YSYX_22041752_ILINE_BUF_EN.
module ysyx_22041752_ifetch_bridge #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_en,
    input  logic [ADDR_WD-1:0] inst_addr,
    output logic               inst_ready,
    output logic [DATA_WD-1:0] inst_rdata,
    output logic               inst_err,
    input  logic               flush,
    output logic               arvalid,
    input  logic               arready,
    output logic [ADDR_WD-1:0] araddr,
    input  logic               rvalid,
    output logic               rready,
    input  logic [DATA_WD-1:0] rdata,
    input  logic [1:0]         rresp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 arvalid_q, arvalid_d;
    logic [ADDR_WD-4:0]   addr_q, addr_d;
    logic [DATA_WD-1:0]   rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 drop_q, drop_d;
    logic                 hit_q, hit_d;
    logic                 accept;
    logic                 line_hit;
    logic                 unused_addr_lo;

    assign unused_addr_lo = ^inst_addr[2:0];

`ifdef YSYX_22041752_ILINE_BUF_EN
    // The buffered line data is always the current inst_rdata: every fill
    // also loads inst_rdata, and anything else that changes it invalidates.
    logic [ADDR_WD-4:0]   tag_q, tag_d;
    logic                 tvalid_q, tvalid_d;

    assign line_hit = tvalid_q && (tag_q == inst_addr[ADDR_WD-1:3]);
`else
    assign line_hit = 1'b0;
`endif

    assign inst_ready = reset && (state_q == IDLE) && !hit_q;
    assign accept     = inst_ready && inst_en;
    assign rready     = (state_q == DATA);
    assign arvalid    = arvalid_q;
    assign araddr     = {addr_q, 3'b000};
    assign inst_rdata = rdata_q;
    assign inst_err   = err_q;

    // Next-state logic for the request/response sequence
    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        drop_d    = drop_q;
        hit_d     = 1'b0;
`ifdef YSYX_22041752_ILINE_BUF_EN
        tag_d     = tag_q;
        tvalid_d  = tvalid_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (line_hit) begin
                        hit_d = 1'b1;
                    end else begin
                        addr_d    = inst_addr[ADDR_WD-1:3];
                        arvalid_d = 1'b1;
                        drop_d    = 1'b0;
                        state_d   = ADDR;
                    end
                end
            end
            ADDR: begin
                if (flush) drop_d = 1'b1;
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (flush) drop_d = 1'b1;
                if (rvalid) begin
                    state_d = IDLE;
                    if (!drop_q && !flush) begin
                        rdata_d = rdata;
                        err_d   = (rresp != 2'b00);
`ifdef YSYX_22041752_ILINE_BUF_EN
                        tag_d    = addr_q;
                        tvalid_d = (rresp == 2'b00);
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
            hit_q     <= 1'b0;
`ifdef YSYX_22041752_ILINE_BUF_EN
            tag_q     <= '0;
            tvalid_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            hit_q     <= hit_d;
`ifdef YSYX_22041752_ILINE_BUF_EN
            tag_q     <= tag_d;
            tvalid_q  <= tvalid_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_ifetch_bridge.sv
// Bench for ysyx_22041752_ifetch_bridge: directed fetches plus random ones,
// checked against a transaction-level model of the fetch port.
module tb_ysyx_22041752_ifetch_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_en = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_ready;
    logic [63:0] inst_rdata;
    logic        inst_err;
    logic        flush = 1'b0;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] araddr;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [63:0] rdata = '0;
    logic [1:0]  rresp = '0;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic        bvalid = 1'b0;
    logic [28:0] btag = '0;

    ysyx_22041752_ifetch_bridge dut (
        .clk(clk), .reset(reset),
        .inst_en(inst_en), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .inst_rdata(inst_rdata),
        .inst_err(inst_err), .flush(flush),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // fl: 0 none, 1 flush in first ADDR cycle, 2 flush in first DATA
    // cycle, 3 flush together with the rvalid beat
    task automatic fetch(input logic [31:0] a, input int arw, input int rw,
                         input logic [63:0] d, input logic [1:0] rs,
                         input int fl);
        logic [31:0] al;
        bit hit;
        bit drop;
        al = {a[31:3], 3'b000};
        hit = 0;
        drop = 0;
`ifdef YSYX_22041752_ILINE_BUF_EN
        hit = bvalid && (btag == a[31:3]);
`endif
        chk("ready_pre", inst_ready, 1);
        inst_en = 1;
        inst_addr = a;
        step();
        inst_en = 0;
        inst_addr = $urandom;
        if (hit) begin
            exp_err = 0;
            chk("hit_no_ar", arvalid, 0);
            chk("hit_busy", inst_ready, 0);
            chk("hit_data", inst_rdata, exp_rdata);
            chk("hit_err", inst_err, 0);
            step();
            chk("hit_ready", inst_ready, 1);
            chk("hit_no_ar2", arvalid, 0);
            return;
        end
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, {32'd0, al});
        chk("busy_addr", inst_ready, 0);
        for (int i = 0; i < arw; i++) begin
            arready = 0;
            inst_en = 1'($urandom_range(0, 1));
            inst_addr = $urandom;
            if (fl == 1 && i == 0) begin
                flush = 1;
                drop = 1;
            end
            step();
            flush = 0;
            chk("ar_hold", arvalid, 1);
            chk("ar_stable", araddr, {32'd0, al});
            chk("rready_addr", rready, 0);
            chk("busy_wait", inst_ready, 0);
        end
        inst_en = 0;
        if (fl == 1 && arw == 0) begin
            flush = 1;
            drop = 1;
        end
        arready = 1;
        step();
        arready = 0;
        flush = 0;
        for (int i = 0; i < rw; i++) begin
            chk("rready_data", rready, 1);
            chk("no_second_ar", arvalid, 0);
            chk("busy_data", inst_ready, 0);
            if (fl == 2 && i == 0) begin
                flush = 1;
                drop = 1;
            end
            rvalid = 0;
            step();
            flush = 0;
        end
        chk("rready_beat", rready, 1);
        chk("no_ar_beat", arvalid, 0);
        if ((fl == 2 && rw == 0) || fl == 3) begin
            flush = 1;
            drop = 1;
        end
        rvalid = 1;
        rdata = d;
        rresp = rs;
        step();
        rvalid = 0;
        flush = 0;
        rdata = {$urandom, $urandom};
        rresp = 2'($urandom);
        if (!drop) begin
            exp_rdata = d;
            exp_err = (rs != 2'b00);
            bvalid = (rs == 2'b00);
            btag = al[31:3];
        end else begin
            exp_err = 0;
        end
        chk("ready_post", inst_ready, 1);
        chk("rdata", inst_rdata, exp_rdata);
        chk("err", inst_err, {63'd0, exp_err});
        chk("no_ar_post", arvalid, 0);
        chk("rready_post", rready, 0);
        step();
        exp_err = 0;
        chk("err_clear", inst_err, 0);
        chk("rdata_hold", inst_rdata, exp_rdata);
        chk("ready_idle", inst_ready, 1);
    endtask

    initial begin
        reset = 0;
        step();
        step();
        chk("rst_ready", inst_ready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_rdata", inst_rdata, 0);
        chk("rst_err", inst_err, 0);
        chk("rst_rready", rready, 0);
        reset = 1;
        step();
        chk("rst_rel_ready", inst_ready, 1);

        fetch(32'h8000_0004, 0, 0, 64'h1111_2222_3333_4444, 2'b00, 0);
        fetch(32'h8000_0104, 4, 0, 64'h5555_6666_7777_8888, 2'b00, 0);
        fetch(32'h8000_0200, 0, 2, 64'h0000_0000_0000_DEAD, 2'b00, 2);
        fetch(32'h8000_0300, 0, 0, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10, 0);
        fetch(32'h8000_0400, 1, 1, 64'h0123_4567_89AB_CDEF, 2'b00, 3);
        fetch(32'h8000_0500, 2, 0, 64'hFEDC_BA98_7654_3210, 2'b01, 1);
        fetch(32'h8000_0000, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0);
        fetch(32'h8000_0004, 0, 0, 64'h9999_9999_9999_9999, 2'b00, 0);
        fetch(32'h8000_0008, 0, 0, 64'h7777_0000_7777_0000, 2'b00, 0);

        for (int n = 0; n < 60; n++) begin
            fetch(32'h8000_0000 + 32'($urandom_range(0, 15)) * 4,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  {$urandom, $urandom},
                  ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00,
                  int'($urandom_range(0, 5)) - 2 < 0 ? 0
                      : int'($urandom_range(0, 3)));
        end

        inst_en = 1;
        inst_addr = 32'h8000_0F00;
        if (bvalid && btag == inst_addr[31:3]) inst_addr = 32'h8000_0F80;
        step();
        inst_en = 0;
        chk("mid_arvalid", arvalid, 1);
        reset = 0;
        step();
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_ready", inst_ready, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_rdata", inst_rdata, 0);
        reset = 1;
        exp_rdata = '0;
        exp_err = 0;
        bvalid = 0;
        step();
        chk("mid_rel_ready", inst_ready, 1);
        fetch(32'h8000_0008, 1, 1, 64'h1357_9BDF_2468_ACE0, 2'b00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
